// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one sequential 8-bit divider among NUM_REQ clients,
// with a watchdog that aborts a division the divider never finishes.
module divider_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [NUM_REQ*8-1:0] req_dividend_i,
  input  logic [NUM_REQ*8-1:0] req_divisor_i,
  output logic [NUM_REQ-1:0]   resp_valid_o,
  input  logic [NUM_REQ-1:0]   resp_ready_i,
  output logic [8:0]           resp_quotient_o,
  output logic                 resp_err_o,
  output logic                 div_start_o,
  output logic [7:0]           div_dividend_o,
  output logic [7:0]           div_divisor_o,
  input  logic                 div_busy_i,
  input  logic                 div_finish_i,
  input  logic [8:0]           div_quotient_i
);

  localparam int IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   rrPtr_q, rrPtr_d;
  logic [IdW-1:0]   owner_q, owner_d;
  logic [7:0]       dividend_q, dividend_d;
  logic [7:0]       divisor_q, divisor_d;
  logic [8:0]       quotient_q, quotient_d;
  logic             err_q, err_d;
  logic [CntW-1:0]  wdCnt_q, wdCnt_d;

  logic             grantFound;
  logic [IdW-1:0]   grantIdx;
  logic [NUM_REQ-1:0] reqReady;
  logic [NUM_REQ-1:0] respValid;
  logic             divStart;
  logic [CntW-1:0]  wdNext;

  function automatic logic [IdW-1:0] wrapIdx(input int base, input int off);
    int sum;
    sum = base + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IdW'(sum);
  endfunction

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grantFound && req_valid_i[wrapIdx(int'(rrPtr_q), i)]) begin
        grantFound = 1'b1;
        grantIdx   = wrapIdx(int'(rrPtr_q), i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    owner_d    = owner_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quotient_d = quotient_q;
    err_d      = err_q;
    wdCnt_d    = wdCnt_q;
    reqReady   = '0;
    respValid  = '0;
    divStart   = 1'b0;
    wdNext     = wdCnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (grantFound && !div_busy_i) begin
          reqReady[grantIdx] = 1'b1;
          dividend_d = req_dividend_i[int'(grantIdx)*8 +: 8];
          divisor_d  = req_divisor_i[int'(grantIdx)*8 +: 8];
          owner_d    = grantIdx;
          rrPtr_d    = wrapIdx(int'(grantIdx), 1);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        divStart = 1'b1;
        wdCnt_d  = '0;
        state_d  = ARM;
      end
      // A finish level left over from the previous division is ignored here.
      ARM: state_d = WAIT;
      WAIT: begin
        if (div_finish_i && !div_busy_i) begin
          quotient_d = div_quotient_i;
          err_d      = 1'b0;
          state_d    = RESP;
        end else begin
          wdCnt_d = wdNext;
          if (TIMEOUT_CYCLES != 0 && wdNext == CntW'(TIMEOUT_CYCLES)) begin
            quotient_d = '0;
            err_d      = 1'b1;
            state_d    = RESP;
          end
        end
      end
      RESP: begin
        respValid[owner_q] = 1'b1;
        if (resp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      owner_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quotient_q <= '0;
      err_q      <= 1'b0;
      wdCnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      owner_q    <= owner_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quotient_q <= quotient_d;
      err_q      <= err_d;
      wdCnt_q    <= wdCnt_d;
    end
  end

  // The grant is combinational, so it is also masked while reset is held.
  assign req_ready_o     = reqReady & {NUM_REQ{reset_ni}};
  assign resp_valid_o    = respValid;
  assign div_start_o     = divStart;
  assign div_dividend_o  = dividend_q;
  assign div_divisor_o   = divisor_q;
  assign resp_quotient_o = quotient_q;
  assign resp_err_o      = err_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: a delay-model divider, per-requester job queue and a
// response scoreboard checked for grant order, latency, owner, quotient and error.
module tb_divider_arbiter;

  localparam int NumReq   = 4;
  localparam int Timeout  = 16;
  localparam int DivDelay = 9;
  localparam int NormLat  = 12;
  localparam int WdLat    = 18;

  typedef struct {
    int         req;
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [8:0] q;
    logic       err;
    int         lat;
  } job_t;

  typedef struct {
    int         owner;
    logic [8:0] q;
    logic       err;
    int         lat;
    int         acceptCyc;
  } sb_t;

  logic                clk = 1'b0;
  logic                resetN = 1'b0;
  logic [NumReq-1:0]   reqValid = '0;
  logic [NumReq-1:0]   reqReady;
  logic [NumReq*8-1:0] reqDividend = '0;
  logic [NumReq*8-1:0] reqDivisor = '0;
  logic [NumReq-1:0]   respValid;
  logic [NumReq-1:0]   respReady = '1;
  logic [8:0]          respQuot;
  logic                respErr;
  logic                divStart;
  logic [7:0]          divDividend;
  logic [7:0]          divDivisor;
  logic                divBusy = 1'b0;
  logic                divFinish = 1'b0;
  logic [8:0]          divQuot = '0;
  logic                busyIn;
  int                  divCnt = 0;
  bit                  divHang = 1'b0;
  bit                  forceBusy = 1'b0;
  int                  cyc = 0;

  job_t jobQ[$];
  sb_t  sbQ[$];
  int   expGrant[$];
  int   checks = 0;
  int   errors = 0;
  int   grantCount = 0;
  int   startCount = 0;
  bit   prevResp = 1'b0;

  divider_arbiter #(.NUM_REQ(NumReq), .TIMEOUT_CYCLES(Timeout)) dut (
    .clk_i(clk), .reset_ni(resetN),
    .req_valid_i(reqValid), .req_ready_o(reqReady),
    .req_dividend_i(reqDividend), .req_divisor_i(reqDivisor),
    .resp_valid_o(respValid), .resp_ready_i(respReady),
    .resp_quotient_o(respQuot), .resp_err_o(respErr),
    .div_start_o(divStart), .div_dividend_o(divDividend), .div_divisor_o(divDivisor),
    .div_busy_i(busyIn), .div_finish_i(divFinish), .div_quotient_i(divQuot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign busyIn = divBusy | forceBusy;

  // Divider model: finish rises DivDelay+1 edges after the start edge and stays high
  // until the next start; in hang mode a start is swallowed.
  always @(posedge clk) begin
    if (divStart) begin
      divFinish <= 1'b0;
      if (!divHang) begin
        divBusy <= 1'b1;
        divCnt  <= DivDelay;
      end
    end else if (divBusy) begin
      if (divCnt == 0) begin
        divBusy   <= 1'b0;
        divFinish <= 1'b1;
        divQuot   <= (divDivisor == 8'd0) ? 9'h1FF : 9'(divDividend / divDivisor);
      end else begin
        divCnt <= divCnt - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got unexpected event at cycle %0d, want none", name, cyc);
  endtask

  task automatic applyStimulus(input int req, input logic [7:0] dvd, input logic [7:0] dvs,
                               input logic [8:0] q, input logic err, input int lat);
    job_t j;
    j.req = req; j.dvd = dvd; j.dvs = dvs; j.q = q; j.err = err; j.lat = lat;
    jobQ.push_back(j);
  endtask

  task automatic driveRequests();
    logic [NumReq-1:0] v;
    v = '0;
    for (int k = 0; k < NumReq; k++) begin
      for (int j = 0; j < jobQ.size(); j++) begin
        if (!v[k] && jobQ[j].req == k) begin
          v[k] = 1'b1;
          reqDividend[k*8 +: 8] = jobQ[j].dvd;
          reqDivisor[k*8 +: 8]  = jobQ[j].dvs;
        end
      end
    end
    reqValid = v;
  endtask

  // Sampled on the falling edge: grants feed the scoreboard, responses drain it.
  task automatic monitorSample();
    int g;
    int ji;
    sb_t s;
    if (resetN) begin
      if ($countones(reqReady) > 1) failNow("readyOneHot");
      if (reqReady != '0) begin
        g = 0;
        for (int k = NumReq - 1; k >= 0; k--) if (reqReady[k]) g = k;
        checkOutput("grantValid", 32'(reqValid[g]), 32'd1);
        if (expGrant.size() == 0) failNow("unexpectedGrant");
        else checkOutput("grantOrder", g, expGrant.pop_front());
        ji = -1;
        for (int j = jobQ.size() - 1; j >= 0; j--) if (jobQ[j].req == g) ji = j;
        if (ji < 0) failNow("grantNoJob");
        else begin
          s.owner = g; s.q = jobQ[ji].q; s.err = jobQ[ji].err;
          s.lat = jobQ[ji].lat; s.acceptCyc = cyc + 1;
          sbQ.push_back(s);
          jobQ.delete(ji);
        end
        grantCount++;
      end
      if (divStart) startCount++;
      if (respValid != '0) begin
        if (sbQ.size() == 0) failNow("unexpectedResp");
        else begin
          s = sbQ[0];
          if (!prevResp) checkOutput("latency", cyc - s.acceptCyc, s.lat);
          if ((respValid & respReady) != '0) begin
            void'(sbQ.pop_front());
            checkOutput("respOwner", 32'(respValid), 32'd1 << s.owner);
            checkOutput("respQuot", 32'(respQuot), 32'(s.q));
            checkOutput("respErr", 32'(respErr), 32'(s.err));
          end
        end
      end
    end
    prevResp = (respValid != '0);
  endtask

  task automatic tick();
    @(negedge clk);
    monitorSample();
    @(posedge clk);
    #1;
    driveRequests();
  endtask

  task automatic waitDrained(input int bound, input string name);
    int n;
    n = 0;
    while ((jobQ.size() != 0 || sbQ.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: still busy after %0d cycles, jobs=%0d resps=%0d, want 0", name, n, jobQ.size(), sbQ.size());
      jobQ.delete();
      sbQ.delete();
      expGrant.delete();
    end
    tick();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_reqReady"}, 32'(reqReady), 32'd0);
    checkOutput({tag, "_respValid"}, 32'(respValid), 32'd0);
    checkOutput({tag, "_start"}, 32'(divStart), 32'd0);
    checkOutput({tag, "_dividend"}, 32'(divDividend), 32'd0);
    checkOutput({tag, "_divisor"}, 32'(divDivisor), 32'd0);
    checkOutput({tag, "_quot"}, 32'(respQuot), 32'd0);
    checkOutput({tag, "_err"}, 32'(respErr), 32'd0);
  endtask

  initial begin
    job_t vecs[8];
    int base;
    int startBase;
    int n;

    vecs[0] = '{3, 8'd128, 8'd2,  9'd64,  1'b0, NormLat};
    vecs[1] = '{0, 8'd255, 8'd1,  9'd255, 1'b0, NormLat};
    vecs[2] = '{1, 8'd81,  8'd9,  9'd9,   1'b0, NormLat};
    vecs[3] = '{2, 8'd250, 8'd25, 9'd10,  1'b0, NormLat};
    vecs[4] = '{3, 8'd99,  8'd8,  9'd12,  1'b0, NormLat};
    vecs[5] = '{0, 8'd17,  8'd4,  9'd4,   1'b0, NormLat};
    vecs[6] = '{1, 8'd5,   8'd10, 9'd0,   1'b0, NormLat};
    vecs[7] = '{2, 8'd7,   8'd7,  9'd1,   1'b0, NormLat};

    // Reset with a request already pending: nothing may be granted yet.
    resetN = 1'b0;
    expGrant.push_back(1);
    applyStimulus(1, 8'd100, 8'd7, 9'd14, 1'b0, NormLat);
    driveRequests();
    tick();
    tick();
    checkAllZero("reset");
    resetN = 1'b1;

    // Single request from requester 1.
    waitDrained(60, "single");
    checkOutput("singleStarts", startCount, 1);

    // Requesters 0 and 2 together with the pointer back at 0.
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    expGrant.push_back(0);
    expGrant.push_back(2);
    applyStimulus(0, 8'd200, 8'd3, 9'd66, 1'b0, NormLat);
    applyStimulus(2, 8'd50,  8'd5, 9'd10, 1'b0, NormLat);
    waitDrained(80, "pair");

    // All four held valid; the pointer now sits at 3.
    startBase = startCount;
    expGrant.push_back(3); expGrant.push_back(0); expGrant.push_back(1); expGrant.push_back(2);
    expGrant.push_back(3); expGrant.push_back(0); expGrant.push_back(1); expGrant.push_back(2);
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i].req, vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].err, vecs[i].lat);
    waitDrained(300, "allFour");
    checkOutput("allFourStarts", startCount - startBase, 8);

    // Response stalled for 5 cycles while another requester waits.
    respReady = '0;
    expGrant.push_back(1);
    expGrant.push_back(2);
    applyStimulus(1, 8'd60, 8'd6, 9'd10, 1'b0, NormLat);
    applyStimulus(2, 8'd9,  8'd3, 9'd3,  1'b0, NormLat);
    n = 0;
    while (respValid == '0 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("stallReached", 32'(n < 40), 32'd1);
    base = grantCount;
    startBase = startCount;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stallValid", 32'(respValid), 32'b0010);
      checkOutput("stallQuot", 32'(respQuot), 32'd10);
    end
    checkOutput("stallNoGrant", grantCount - base, 0);
    checkOutput("stallNoStart", startCount - startBase, 0);
    respReady = '1;
    waitDrained(80, "stall");

    // Divider hangs: abort after 16 WAIT cycles, then a normal request.
    divHang = 1'b1;
    expGrant.push_back(0);
    applyStimulus(0, 8'd20, 8'd4, 9'd0, 1'b1, WdLat);
    waitDrained(60, "watchdog");
    divHang = 1'b0;
    expGrant.push_back(1);
    applyStimulus(1, 8'd40, 8'd8, 9'd5, 1'b0, NormLat);
    waitDrained(60, "afterWatchdog");

    // Externally busy divider blocks grants.
    forceBusy = 1'b1;
    base = grantCount;
    expGrant.push_back(1);
    applyStimulus(1, 8'd30, 8'd3, 9'd10, 1'b0, NormLat);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("busyNoGrant", grantCount - base, 0);
    checkOutput("busyReady", 32'(reqReady), 32'd0);
    forceBusy = 1'b0;
    waitDrained(60, "busy");

    // Reset during WAIT abandons the transaction and rewinds the pointer.
    expGrant.push_back(1);
    applyStimulus(1, 8'd90, 8'd9, 9'd10, 1'b0, NormLat);
    startBase = startCount;
    n = 0;
    while (startCount == startBase && n < 20) begin
      tick();
      n++;
    end
    checkOutput("midStart", startCount - startBase, 1);
    tick();
    tick();
    tick();
    resetN = 1'b0;
    #1;
    checkAllZero("midReset");
    sbQ.delete();
    tick();
    tick();
    resetN = 1'b1;
    expGrant.push_back(0);
    expGrant.push_back(2);
    applyStimulus(2, 8'd200, 8'd200, 9'd1, 1'b0, NormLat);
    applyStimulus(0, 8'd12,  8'd4,   9'd3, 1'b0, NormLat);
    waitDrained(120, "postReset");

    checkOutput("grantsLeft", expGrant.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: time %0t reached, want completion earlier", $time);
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
